// File: rtl/dlx_pipe_pkg.sv
// Shared DLX pipeline definitions: NOP encoding, scoreboard entry type,
// legal LOAD_LAT range and the scoreboard match helper.
package dlx_pipe_pkg;

  // Canonical NOP instruction word
  localparam logic [31:0] NOP_INSN = 32'h0800_0000;

  // Legal range of load-use bubbles
  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 4;

  // Register-index width held in a scoreboard entry (REG_AW must not exceed it)
  localparam int SB_RD_W = 8;

  // One in-flight load destination
  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
  } sb_entry_t;

  // True when a used source reads the non-zero destination of a valid entry
  function automatic logic sb_hit(input sb_entry_t e,
                                  input logic [SB_RD_W-1:0] src,
                                  input logic used);
    return used & e.valid & (e.rd != {SB_RD_W{1'b0}}) & (e.rd == src);
  endfunction

endpackage

// File: rtl/id_hazard_stage_load_scoreboard.sv
// load_scoreboard: LOAD_LAT-deep shift register of in-flight load
// destinations and the combinational load-use hazard compare.
module load_scoreboard
  import dlx_pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              push_valid,
  input  logic [REG_AW-1:0] push_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_used,
  output logic              hazard
);

  sb_entry_t          sb_r [LOAD_LAT];
  logic [SB_RD_W-1:0] rs1_ext_s;
  logic [SB_RD_W-1:0] rs2_ext_s;
  logic               hit_s;

  assign rs1_ext_s = SB_RD_W'(id_rs1);
  assign rs2_ext_s = SB_RD_W'(id_rs2);

  // Shift a new entry in on every advancing edge; the oldest entry falls off
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LOAD_LAT; k++) begin
        sb_r[k] <= '0;
      end
    end else if (advance) begin
      sb_r[0].valid <= push_valid;
      sb_r[0].rd    <= SB_RD_W'(push_rd);
      for (int k = 1; k < LOAD_LAT; k++) begin
        sb_r[k] <= sb_r[k-1];
      end
    end
  end

  // A valid ID instruction is hazardous if any used source hits a pending load
  always_comb begin
    hit_s = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      hit_s = hit_s | sb_hit(sb_r[k], rs1_ext_s, id_rs1_used)
                    | sb_hit(sb_r[k], rs2_ext_s, id_rs2_used);
    end
    hazard = id_valid & hit_s;
  end

endmodule

// File: rtl/id_hazard_stage.sv
// id_hazard_stage: ID/EX pipeline register with load-use interlock.
// Edge priority is reset > hold > nullify > hazard > normal issue.
// Optional feature: define ID_STALL_CNT_EN to add the 32-bit saturating
// stall_cnt output counting hazard bubbles.
module id_hazard_stage
  import dlx_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 64,
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_AW-1:0]    id_rs1,
  input  logic [REG_AW-1:0]    id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_AW-1:0]    id_rd,
  input  logic                 id_is_load,
  input  logic [PAYLOAD_W-1:0] id_payload,
  input  logic                 nullify,
  input  logic                 hold,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [REG_AW-1:0]    ex_rd,
  output logic [REG_AW-1:0]    ex_rs1,
  output logic [REG_AW-1:0]    ex_rs2,
  output logic                 ex_is_load,
  output logic [PAYLOAD_W-1:0] ex_payload
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  logic hazard_s;
  logic push_valid_s;

  // Only a load that actually issues into EX becomes a pending destination
  assign push_valid_s = id_valid & id_is_load & ~hazard_s & ~nullify;

  load_scoreboard #(
    .REG_AW   (REG_AW),
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .advance     (~hold),
    .push_valid  (push_valid_s),
    .push_rd     (id_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs1_used (id_rs1_used),
    .id_rs2      (id_rs2),
    .id_rs2_used (id_rs2_used),
    .hazard      (hazard_s)
  );

  // During reset the scoreboard contents are stale, so only hold may stall
  assign stall = hold | (hazard_s & ~nullify & ~reset);

  // ID/EX register: freeze on hold, bubble on nullify or hazard, else capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_rd      <= {REG_AW{1'b0}};
      ex_rs1     <= {REG_AW{1'b0}};
      ex_rs2     <= {REG_AW{1'b0}};
      ex_is_load <= 1'b0;
      ex_payload <= {PAYLOAD_W{1'b0}};
    end else if (hold) begin
      ex_valid   <= ex_valid;
      ex_rd      <= ex_rd;
      ex_rs1     <= ex_rs1;
      ex_rs2     <= ex_rs2;
      ex_is_load <= ex_is_load;
      ex_payload <= ex_payload;
    end else if (nullify || hazard_s) begin
      ex_valid   <= 1'b0;
      ex_rd      <= {REG_AW{1'b0}};
      ex_rs1     <= {REG_AW{1'b0}};
      ex_rs2     <= {REG_AW{1'b0}};
      ex_is_load <= 1'b0;
      ex_payload <= {PAYLOAD_W{1'b0}};
    end else begin
      ex_valid   <= id_valid;
      ex_rd      <= id_rd;
      ex_rs1     <= id_rs1;
      ex_rs2     <= id_rs2;
      ex_is_load <= id_is_load;
      ex_payload <= id_payload;
    end
  end

`ifdef ID_STALL_CNT_EN
  // Count bubbles actually inserted for load-use hazards, saturating at max
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'h0000_0000;
    end else if (hazard_s && !hold && !nullify && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'h0000_0001;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_id_hazard_stage.sv
// Self-checking bench for id_hazard_stage: three instances (LOAD_LAT 1..3)
// share one stimulus stream; expected results are queued at drive time and
// compared when the DUT produces them.
module tb_id_hazard_stage;

  localparam int PW = 64;
  localparam int AW = 5;
  localparam int BUB  = 0;
  localparam int CAP  = 1;
  localparam int KEEP = 2;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic          u1;
    logic [AW-1:0] rs2;
    logic          u2;
    logic          ld;
  } ins_t;

  typedef struct packed {
    logic          stall;
    logic          v;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          ld;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, id_valid, id_rs1_used, id_rs2_used, id_is_load, nullify, hold;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [PW-1:0] id_payload;

  logic          stall_o    [1:3];
  logic          ex_valid_o [1:3];
  logic [AW-1:0] ex_rd_o    [1:3];
  logic [AW-1:0] ex_rs1_o   [1:3];
  logic [AW-1:0] ex_rs2_o   [1:3];
  logic          ex_ld_o    [1:3];
  logic [PW-1:0] ex_pl_o    [1:3];
`ifdef ID_STALL_CNT_EN
  logic [31:0]   stall_cnt_o [1:3];
`endif

  int   checks   = 0;
  int   failures = 0;
  int   sel      = 1;
  exp_t exp_q[$];
  exp_t last_ex  = '0;
  ins_t idle     = '0;

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    id_hazard_stage #(
      .PAYLOAD_W (PW),
      .REG_AW    (AW),
      .LOAD_LAT  (g)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .id_rd       (id_rd),
      .id_is_load  (id_is_load),
      .id_payload  (id_payload),
      .nullify     (nullify),
      .hold        (hold),
      .stall       (stall_o[g]),
      .ex_valid    (ex_valid_o[g]),
      .ex_rd       (ex_rd_o[g]),
      .ex_rs1      (ex_rs1_o[g]),
      .ex_rs2      (ex_rs2_o[g]),
      .ex_is_load  (ex_ld_o[g]),
      .ex_payload  (ex_pl_o[g])
`ifdef ID_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt_o[g])
`endif
    );
  end

  function automatic logic [PW-1:0] pl_of(input logic v, input logic [AW-1:0] rd,
                                          input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    return v ? {32'hC0DE_0000, 3'b000, rd, 3'b000, rs1, 3'b000, rs2, 8'h5A} : 64'h0;
  endfunction

  function automatic ins_t mk(input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic u1,
                              input logic [AW-1:0] rs2, input logic u2, input logic ld);
    ins_t i;
    i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2; i.ld = ld;
    return i;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s lat=%0d t=%0t observed=%0h expected=%0h", tag, sel, $time, obs, exp);
    end
  endtask

  // One clock: drive ID inputs, queue the expectation, check stall then EX
  task automatic cyc(input logic rst, input logic hld, input logic nul, input ins_t i,
                     input logic e_stall, input int kind);
    exp_t e;
    reset = rst; hold = hld; nullify = nul;
    id_valid = i.v; id_rd = i.rd; id_rs1 = i.rs1; id_rs1_used = i.u1;
    id_rs2 = i.rs2; id_rs2_used = i.u2; id_is_load = i.ld;
    id_payload = pl_of(i.v, i.rd, i.rs1, i.rs2);
    case (kind)
      CAP:     begin e = '0; e.v = i.v; e.rd = i.rd; e.rs1 = i.rs1; e.rs2 = i.rs2; e.ld = i.ld; end
      KEEP:    e = last_ex;
      default: e = '0;
    endcase
    e.stall = e_stall;
    last_ex = e;
    exp_q.push_back(e);
    @(negedge clk);
    check_eq("stall", stall_o[sel], exp_q[0].stall);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("ex_valid",   ex_valid_o[sel], e.v);
    check_eq("ex_rd",      ex_rd_o[sel],    e.rd);
    check_eq("ex_rs1",     ex_rs1_o[sel],   e.rs1);
    check_eq("ex_rs2",     ex_rs2_o[sel],   e.rs2);
    check_eq("ex_is_load", ex_ld_o[sel],    e.ld);
    check_eq("ex_payload", ex_pl_o[sel],    pl_of(e.v, e.rd, e.rs1, e.rs2));
  endtask

  initial begin
    // Reset state; stall mirrors hold while reset is asserted
    sel = 1;
    cyc(1'b1, 1'b0, 1'b0, idle, 1'b0, BUB);
    cyc(1'b1, 1'b1, 1'b0, idle, 1'b1, BUB);
`ifdef ID_STALL_CNT_EN
    check_eq("stall_cnt_reset", stall_cnt_o[1], 32'd0);
`endif

    // LOAD_LAT=1: load r3 then reader of r3 -> one bubble
    cyc(1'b0, 1'b0, 1'b0, mk(5'd3, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1), 1'b0, CAP);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd4, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0), 1'b1, BUB);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd4, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0), 1'b0, CAP);
    cyc(1'b0, 1'b0, 1'b0, idle, 1'b0, CAP);

    // r0 never hazards; an unused source never hazards
    cyc(1'b0, 1'b0, 1'b0, mk(5'd0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1), 1'b0, CAP);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd6, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0), 1'b0, CAP);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1), 1'b0, CAP);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd9, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0), 1'b0, CAP);

    // Nullify overrides a pending hazard and pushes an invalid entry
    cyc(1'b0, 1'b0, 1'b0, mk(5'd3, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1), 1'b0, CAP);
    cyc(1'b0, 1'b0, 1'b1, mk(5'd4, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0), 1'b0, BUB);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd4, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0), 1'b0, CAP);
    // A nullified load must not become a pending destination
    cyc(1'b0, 1'b0, 1'b1, mk(5'd8, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1), 1'b0, BUB);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd10, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0), 1'b0, CAP);

    // LOAD_LAT=3: load r7 then rs2 reader -> three bubbles
    sel = 3;
    cyc(1'b1, 1'b0, 1'b0, idle, 1'b0, BUB);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd7, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1), 1'b0, CAP);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, mk(5'd11, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0), 1'b1, BUB);
    end
    cyc(1'b0, 1'b0, 1'b0, mk(5'd11, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0), 1'b0, CAP);
`ifdef ID_STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt_o[3], 32'd3);
`endif

    // Reset mid-stall drops the pending hazard
    cyc(1'b0, 1'b0, 1'b0, mk(5'd7, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1), 1'b0, CAP);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd14, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0), 1'b1, BUB);
    cyc(1'b1, 1'b0, 1'b0, mk(5'd14, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0), 1'b0, BUB);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd14, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0), 1'b0, CAP);

    // LOAD_LAT=2 with hold: EX frozen, held cycles do not count as bubbles
    sel = 2;
    cyc(1'b1, 1'b0, 1'b0, idle, 1'b0, BUB);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd12, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0), 1'b0, CAP);
    cyc(1'b0, 1'b1, 1'b0, mk(5'd7, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1), 1'b1, KEEP);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd7, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1), 1'b0, CAP);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd13, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0), 1'b1, BUB);
    cyc(1'b0, 1'b1, 1'b0, mk(5'd13, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0), 1'b1, KEEP);
    cyc(1'b0, 1'b1, 1'b1, mk(5'd13, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0), 1'b1, KEEP);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd13, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0), 1'b1, BUB);
    cyc(1'b0, 1'b0, 1'b0, mk(5'd13, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0), 1'b0, CAP);
    cyc(1'b0, 1'b0, 1'b0, idle, 1'b0, CAP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
